// File: rtl/gmm_ram_arbiter.sv
// Two-requester arbiter for the GMM parameter RAM port: round-robin between host (A)
// and update engine (B), with an RMW lock for B, a lock watchdog and read-return routing.
module gmm_ram_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 256,
    parameter int BE_W     = 32,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_writedata,
    input  logic [BE_W-1:0]   a_byteenable,
    output logic              a_waitrequest,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_writedata,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic              b_lock,
    output logic              b_waitrequest,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,
    output logic              lock_timeout,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCK_B = 1'b1
    } state_e;

    // last_grant encoding: 1 means B was served last, so A wins the next tie
    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [RD_LAT-1:0]  rv_q, rv_d;
    logic [RD_LAT-1:0]  ro_q, ro_d;

    logic a_req_s;
    logic b_req_s;
    logic grant_a_s;
    logic grant_b_s;
    logic lock_timeout_s;

    // Grant decision, lock FSM next state and watchdog
    always_comb begin
        a_req_s        = a_read | a_write;
        b_req_s        = b_read | b_write;
        grant_a_s      = 1'b0;
        grant_b_s      = 1'b0;
        lock_timeout_s = 1'b0;
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        lock_cnt_d     = lock_cnt_q;
        if (reset) begin
            state_d = ST_ARB;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (a_req_s && b_req_s) begin
                        if (last_grant_q) begin
                            grant_a_s = 1'b1;
                        end else begin
                            grant_b_s = 1'b1;
                        end
                    end else if (a_req_s) begin
                        grant_a_s = 1'b1;
                    end else if (b_req_s) begin
                        grant_b_s = 1'b1;
                    end else begin
                        grant_a_s = 1'b0;
                    end
                    if (grant_a_s) begin
                        last_grant_d = 1'b0;
                    end else if (grant_b_s) begin
                        last_grant_d = 1'b1;
                    end else begin
                        last_grant_d = last_grant_q;
                    end
                    if (grant_b_s && b_lock) begin
                        state_d    = ST_LOCK_B;
                        lock_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_ARB;
                    end
                end
                ST_LOCK_B: begin
                    grant_b_s  = b_req_s;
                    lock_cnt_d = lock_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    // Dropping b_lock releases whether or not B is issuing a command
                    if (!b_lock) begin
                        state_d      = ST_ARB;
                        last_grant_d = 1'b1;
                    end else if (lock_cnt_q == CNT_LAST) begin
                        state_d        = ST_ARB;
                        last_grant_d   = 1'b1;
                        lock_timeout_s = 1'b1;
                    end else begin
                        state_d = ST_LOCK_B;
                    end
                end
                default: begin
                    state_d = ST_ARB;
                end
            endcase
        end
    end

    // Command mux onto the RAM port and requester handshakes
    always_comb begin
        ram_clken      = 1'b1;
        ram_chipselect = grant_a_s | grant_b_s;
        ram_write      = 1'b0;
        ram_address    = b_address;
        ram_writedata  = b_writedata;
        ram_byteenable = b_byteenable;
        if (grant_a_s) begin
            ram_write      = a_write;
            ram_address    = a_address;
            ram_writedata  = a_writedata;
            ram_byteenable = a_byteenable;
        end else if (grant_b_s) begin
            ram_write = b_write;
        end else begin
            ram_write = 1'b0;
        end
        if (reset) begin
            a_waitrequest = 1'b1;
            b_waitrequest = 1'b1;
        end else begin
            a_waitrequest = a_req_s & ~grant_a_s;
            b_waitrequest = b_req_s & ~grant_b_s;
        end
        lock_timeout = lock_timeout_s;
    end

    // Read-return pipe: tracks which requester owns each read in flight
    always_comb begin
        rv_d    = '0;
        ro_d    = '0;
        rv_d[0] = (grant_a_s & a_read) | (grant_b_s & b_read);
        ro_d[0] = grant_b_s;
        for (int i = 1; i < RD_LAT; i++) begin
            rv_d[i] = rv_q[i-1];
            ro_d[i] = ro_q[i-1];
        end
        a_readdata      = ram_readdata;
        b_readdata      = ram_readdata;
        if (reset) begin
            a_readdatavalid = 1'b0;
            b_readdatavalid = 1'b0;
        end else begin
            a_readdatavalid = rv_q[RD_LAT-1] & ~ro_q[RD_LAT-1];
            b_readdatavalid = rv_q[RD_LAT-1] &  ro_q[RD_LAT-1];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ARB;
            last_grant_q <= 1'b1;
            lock_cnt_q   <= {CNT_W{1'b0}};
            rv_q         <= '0;
            ro_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            rv_q         <= rv_d;
            ro_q         <= ro_d;
        end
    end

endmodule

// File: tb/tb_gmm_ram_arbiter.sv
// Directed-vector bench for gmm_ram_arbiter: per-cycle handshake checks plus a read-return
// scoreboard fed by the driver and drained by an independent monitor.
module tb_gmm_ram_arbiter;

    localparam logic [31:0] BE_A = 32'h0000_FFFF;
    localparam logic [31:0] BE_B = 32'hF0F0_0F0F;

    logic         clk = 1'b0;
    logic         reset;
    logic [5:0]   a_address, b_address, ram_address;
    logic         a_read, a_write, b_read, b_write, b_lock;
    logic [255:0] a_writedata, b_writedata, ram_writedata;
    logic [31:0]  a_byteenable, b_byteenable, ram_byteenable;
    logic         a_waitrequest, a_readdatavalid, b_waitrequest, b_readdatavalid;
    logic [255:0] a_readdata, b_readdata, ram_readdata;
    logic         lock_timeout, ram_chipselect, ram_write, ram_clken;

    typedef struct {
        logic         own_b;
        logic [255:0] data;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [255:0] shadow [64];
    logic [255:0] mem [64];
    logic [255:0] rdq;
    logic         loaded = 1'b0;
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    gmm_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .a_address(a_address), .a_read(a_read), .a_write(a_write),
        .a_writedata(a_writedata), .a_byteenable(a_byteenable),
        .a_waitrequest(a_waitrequest), .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_read(b_read), .b_write(b_write),
        .b_writedata(b_writedata), .b_byteenable(b_byteenable), .b_lock(b_lock),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .lock_timeout(lock_timeout),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    function automatic logic [255:0] init_word(input int a);
        return {8{32'h5EED_0000 | 32'(a)}};
    endfunction

    function automatic logic [255:0] wpat_a(input int a);
        return {8{32'hAAAA_0000 | 32'(a)}};
    endfunction

    function automatic logic [255:0] wpat_b(input int a);
        return {8{32'hBBBB_0000 | 32'(a)}};
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] nw,
                                           input logic [31:0] be);
        logic [255:0] r;
        r = old;
        for (int j = 0; j < 32; j++) begin
            if (be[j]) r[8*j +: 8] = nw[8*j +: 8];
        end
        return r;
    endfunction

    // RAM s1 model: registered address, 1-cycle read latency
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (ram_chipselect && ram_write) begin
            mem[ram_address] <= merge(mem[ram_address], ram_writedata, ram_byteenable);
        end else if (ram_chipselect) begin
            rdq <= mem[ram_address];
        end
    end
    assign ram_readdata = rdq;

    always @(posedge clk) begin
        assert (!(a_read && a_write)) else $error("illegal simultaneous a_read and a_write");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // One clock of stimulus plus the handshake/RAM-side expectations for that cycle
    task automatic cyc(input bit rst, input bit ar, input bit aw, input int aa,
                       input bit br, input bit bw, input bit bl, input int ba,
                       input bit e_aw, input bit e_bw, input bit e_cs, input bit e_wr,
                       input int e_ad, input bit e_to, input bit ret);
        logic ob;
        @(posedge clk);
        #1;
        reset        = rst;
        a_read       = ar;
        a_write      = aw;
        a_address    = 6'(aa);
        a_writedata  = wpat_a(aa);
        a_byteenable = BE_A;
        b_read       = br;
        b_write      = bw;
        b_lock       = bl;
        b_address    = 6'(ba);
        b_writedata  = wpat_b(ba);
        b_byteenable = BE_B;
        #3;
        chk("a_waitrequest", 256'(a_waitrequest), 256'(e_aw));
        chk("b_waitrequest", 256'(b_waitrequest), 256'(e_bw));
        chk("ram_chipselect", 256'(ram_chipselect), 256'(e_cs));
        chk("ram_write", 256'(ram_write), 256'(e_wr));
        chk("lock_timeout", 256'(lock_timeout), 256'(e_to));
        if (e_cs) begin
            chk("ram_address", 256'(ram_address), 256'(e_ad));
            ob = !((ar || aw) && !e_aw);
            if (e_wr) begin
                chk("ram_writedata", ram_writedata, ob ? wpat_b(e_ad) : wpat_a(e_ad));
                chk("ram_byteenable", 256'(ram_byteenable), 256'(ob ? BE_B : BE_A));
                shadow[e_ad] = merge(shadow[e_ad], ob ? wpat_b(e_ad) : wpat_a(e_ad),
                                     ob ? BE_B : BE_A);
            end else if (ret) begin
                exp_q.push_back('{own_b: ob, data: shadow[e_ad]});
            end
        end
    endtask

    // Monitor: every read-data strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (a_readdatavalid || b_readdatavalid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_readdatavalid", 256'({a_readdatavalid, b_readdatavalid}), 256'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdv_owner", 256'({a_readdatavalid, b_readdatavalid}),
                    mon_e.own_b ? 256'(2'b01) : 256'(2'b10));
                chk("readdata", mon_e.own_b ? b_readdata : a_readdata, mon_e.data);
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        reset = 1'b1; a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
        b_lock = 1'b0; a_address = '0; b_address = '0; a_writedata = '0; b_writedata = '0;
        a_byteenable = '0; b_byteenable = '0;

        // reset: both stalled, port idle
        cyc(1, 0,0,0, 0,0,0,0, 1,1,0,0,0,0,0);
        cyc(1, 0,0,0, 0,0,0,0, 1,1,0,0,0,0,0);
        chk("ram_clken", 256'(ram_clken), 256'(1));

        // A alone: read 5, write 5, read 5 back
        cyc(0, 1,0,5, 0,0,0,0, 0,0,1,0,5,0,1);
        cyc(0, 0,1,5, 0,0,0,0, 0,0,1,1,5,0,0);
        cyc(0, 1,0,5, 0,0,0,0, 0,0,1,0,5,0,1);
        cyc(0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);

        // both read every cycle after reset: A,B,A,B,A,B
        cyc(1, 0,0,0, 0,0,0,0, 1,1,0,0,0,0,0);
        cyc(0, 1,0,10, 1,0,0,20, 0,1,1,0,10,0,1);
        cyc(0, 1,0,11, 1,0,0,20, 1,0,1,0,20,0,1);
        cyc(0, 1,0,11, 1,0,0,21, 0,1,1,0,11,0,1);
        cyc(0, 1,0,12, 1,0,0,21, 1,0,1,0,21,0,1);
        cyc(0, 1,0,12, 1,0,0,22, 0,1,1,0,12,0,1);
        cyc(0, 1,0,13, 1,0,0,22, 1,0,1,0,22,0,1);
        cyc(0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);

        // locked RMW on 9: A stalled until B releases, then served
        cyc(0, 0,0,0, 1,0,1,9, 0,0,1,0,9,0,1);
        cyc(0, 1,0,3, 0,0,1,0, 1,0,0,0,0,0,0);
        cyc(0, 1,0,3, 0,1,0,9, 1,0,1,1,9,0,0);
        cyc(0, 1,0,3, 0,0,0,0, 0,0,1,0,3,0,1);
        cyc(0, 0,0,0, 1,0,0,9, 0,0,1,0,9,0,1);
        cyc(0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);

        // lock watchdog: B sits idle holding the lock
        cyc(0, 0,0,0, 1,0,1,7, 0,0,1,0,7,0,1);
        for (int k = 1; k <= 15; k++) cyc(0, 1,0,4, 0,0,1,0, 1,0,0,0,0,0,0);
        cyc(0, 1,0,4, 0,0,1,0, 1,0,0,0,0,1,0);
        cyc(0, 1,0,4, 0,0,1,0, 0,0,1,0,4,0,1);
        cyc(0, 0,0,0, 0,0,1,0, 0,0,0,0,0,0,0);
        cyc(0, 0,0,0, 0,0,1,0, 0,0,0,0,0,0,0);

        // reset with an A read in flight: read discarded, first tie goes to A
        cyc(0, 1,0,6, 0,0,0,0, 0,0,1,0,6,0,0);
        cyc(1, 1,0,1, 1,0,0,2, 1,1,0,0,0,0,0);
        cyc(0, 1,0,1, 1,0,0,2, 0,1,1,0,1,0,1);
        cyc(0, 0,0,0, 1,0,0,2, 0,0,1,0,2,0,1);
        cyc(0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);
        cyc(0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);

        chk("outstanding_reads", 256'(exp_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gmm_ram_arbiter.md
Name: gmm_ram_arbiter

Overview:
- Shares port s1 (64 x 256-bit, byte-enabled, 1-cycle read latency) of the GMM parameter RAM between two Avalon-MM requesters: host configuration master (A) and GMM update engine (B).
- Engine performs read-modify-write per pixel-model word and holds the port across the RMW via a lock.
- Round-robin arbitration, lock watchdog, and per-requester read-data return routing.
- Sits between the HPS/DMA interconnect, the GMM pipeline and the RAM slave port.

Parameters:
ADDR_W, 6, RAM word address width
DATA_W, 256, data width
BE_W, 32, byte-enable width (DATA_W/8)
RD_LAT, 1, RAM read latency in cycles (address registered, q unregistered)
LOCK_MAX, 16, max consecutive cycles B may hold lock before forced release

Ports:
- Clock and reset (already decided): single clock `clk`; reset `reset` is synchronous and active-high.
clk  in  1  single clock; RAM on same clock
reset  in  1  synchronous, active-high
a_address  in  ADDR_W  host word address
a_read / a_write  in  1  host command strobes (mutually exclusive)
a_writedata  in  DATA_W  host write data
a_byteenable  in  BE_W  host byte enables
a_waitrequest  out  1  host stall
a_readdata  out  DATA_W  host read data
a_readdatavalid  out  1  host read data strobe
b_address, b_read, b_write, b_writedata, b_byteenable  in  as A  engine command
b_lock  in  1  keep grant after this command (RMW)
b_waitrequest, b_readdata, b_readdatavalid  out  as A  engine response
lock_timeout  out  1  one-cycle pulse on forced lock release
ram_address  out  ADDR_W  to RAM s1 address
ram_chipselect, ram_write  out  1  to RAM s1
ram_writedata  out  DATA_W  to RAM s1
ram_byteenable  out  BE_W  to RAM s1
ram_clken  out  1  constant 1
ram_readdata  in  DATA_W  from RAM s1 q

Behaviour:
- States:
  - ARB: no lock; grant computed each cycle.
  - LOCK_B: B owns the port.
- ARB, grant rule:
  - Only one requester active: grant it.
  - Both active: grant the requester not in last_grant, then update last_grant.
  - Neither active: ram_chipselect=0; last_grant unchanged.
- Grant is combinational in the same cycle. Command accepted when req & ~waitrequest.
  - Non-granted requester sees waitrequest=1.
  - Idle requester sees waitrequest=0.
- Accepted command drives ram_* in the same cycle: chipselect=1, write=cmd write, address/data/byteenable muxed from owner.
- B command accepted with b_lock=1: go to LOCK_B, lock_cnt=0.
- LOCK_B:
  - a_waitrequest=1 whenever a_read|a_write.
  - B is served every cycle it requests.
  - lock_cnt increments each cycle.
  - Exit to ARB when an accepted B command has b_lock=0, or b_lock is low while B is idle; set last_grant=B.
  - lock_cnt == LOCK_MAX-1 with no exit: forced exit to ARB next cycle, lock_timeout=1 for one cycle, last_grant=B so A wins the next tie.
- Read return:
  - RD_LAT-deep shift register of {valid, owner}.
  - x_readdatavalid=1 exactly RD_LAT cycles after read acceptance, owner-matched.
  - a_readdata/b_readdata both = ram_readdata (validity by strobe only).
  - Back-to-back reads return in order, one per cycle.
- Hazards:
  - No write/read forwarding; RAM order is acceptance order.
  - A read and then a write to the same address by B in LOCK_B returns old data (write issued after read).
- Reset, synchronous:
  - State=ARB, last_grant=B, lock_cnt=0, return pipe cleared.
  - Outputs during reset: ram_chipselect=0, ram_write=0, readdatavalids=0, lock_timeout=0, both waitrequest=1.
  - In-flight reads at reset are discarded (no readdatavalid).
- Simultaneous a_read & a_write is illegal; behaviour undefined. Bench asserts it never occurs.

Test Plan:
- A reads addr 5 alone:
  - Required: a_waitrequest=0, ram_address=5 same cycle.
  - Required: a_readdatavalid one cycle later with preloaded word.
  - Required: b_readdatavalid stays 0.
- A and B both read every cycle for 6 cycles after reset:
  - Required: grants alternate A,B,A,B,A,B.
  - Required: each readdatavalid routed to the correct requester.
- B reads addr 9 with lock=1, A requests concurrently, B writes addr 9 with lock=0 two cycles later:
  - Required: A stalled throughout.
  - Required: RAM write at 9 with byteenable passthrough.
  - Required: A served the cycle after release.
- B holds b_lock=1 idle for 20 cycles, LOCK_MAX=16:
  - Required: lock_timeout pulses exactly once at cycle 16.
  - Required: A is granted the next cycle.
- Assert reset for 1 cycle while an A read is in flight:
  - Required: no readdatavalid.
  - Required: both waitrequest=1 during reset.
  - Required: first post-reset tie is granted to A.
